// File: rtl/add_operand_fifo_pkg.sv
// -----------------------------------------------------------------------------
// add_operand_fifo_pkg
// Shared defaults and helpers for the adder operand feeder.
//   DEFAULT_WIDTH : operand width used when a parent does not override it
//   DEFAULT_DEPTH : FIFO entries used when a parent does not override it
//   countWidth()  : occupancy counter width able to hold 0..depth inclusive
// -----------------------------------------------------------------------------
package add_operand_fifo_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 4;

  // The counter must represent the full state (count == depth), hence the +1.
  function automatic int countWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/add_operand_fifo_if.sv
// -----------------------------------------------------------------------------
// add_operand_if
// Groups the producer handshake and the issue bus towards the adder.
//   in_valid/in_ready/in_a/in_b : producer valid/ready channel carrying (a, b)
//   A/B/en                      : registered operands and issue strobe
// Modports:
//   master : producer/observer side (drives the pair, sees ready and issue)
//   slave  : the FIFO (accepts the pair, drives ready and issue)
// -----------------------------------------------------------------------------
interface add_operand_if
  import add_operand_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             en;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, A, B, en
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, A, B, en
  );

endinterface

// File: rtl/add_operand_mem.sv
// -----------------------------------------------------------------------------
// add_operand_mem
// DEPTH x 2*WIDTH register array holding buffered operand pairs.
//   clk       : write clock
//   i_wrEn    : write strobe
//   i_wrAddr  : write slot
//   i_wrData  : packed pair {a, b}
//   i_rdAddr  : read slot
//   o_rdData  : combinational read of the addressed slot
// Storage is deliberately not reset; validity is tracked by the owner's count.
// -----------------------------------------------------------------------------
module add_operand_mem
  import add_operand_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               i_wrEn,
  input  logic [AW-1:0]      i_wrAddr,
  input  logic [2*WIDTH-1:0] i_wrData,
  input  logic [AW-1:0]      i_rdAddr,
  output logic [2*WIDTH-1:0] o_rdData
);

  logic [2*WIDTH-1:0] r_mem [DEPTH];

  // Single write port; contents survive reset and flush on purpose.
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/add_operand_fifo.sv
// -----------------------------------------------------------------------------
// add_operand_fifo
// Buffers operand pairs from a producer and issues one pair per cycle to the
// registered adder, as registered A/B plus a one-cycle en strobe.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : add_operand_if.slave (producer handshake + issue outputs)
//   hold   : downstream stall, blocks issue while high
//   flush  : synchronous clear of all buffered pairs, beats push and pop
//   count  : current occupancy, 0..DEPTH
// There is no fall-through: a pair pushed into an empty FIFO issues one edge
// later, which keeps A/B/en purely registered.
// -----------------------------------------------------------------------------
module add_operand_fifo
  import add_operand_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW   = countWidth(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  add_operand_if.slave  bus,
  input  logic          hold,
  input  logic          flush,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0]      r_wrPtr;
  logic [AW-1:0]      r_rdPtr;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_en;
  logic               w_push;
  logic               w_pop;
  logic [2*WIDTH-1:0] w_rdData;

  // Ready comes from the registered count only, so a full FIFO refuses a pair
  // even when a pop happens on the same edge; this keeps ready off the pop path.
  assign bus.in_ready = (r_count != FULL_COUNT);

  // Qualified push/pop events; flush suppresses both.
  always_comb begin
    w_push = bus.in_valid && bus.in_ready && !flush;
    w_pop  = (r_count != '0) && !hold && !flush;
  end

  add_operand_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk      (clk),
    .i_wrEn   (w_push),
    .i_wrAddr (r_wrPtr),
    .i_wrData ({bus.in_a, bus.in_b}),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_rdData)
  );

  // Pointers and occupancy. DEPTH is a power of two, so the natural AW-bit
  // rollover is the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Issue register: A/B only move on a pop so the adder inputs stay stable
  // through stalls and flushes; en is a single-cycle strobe per pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_en <= 1'b0;
    end else if (w_pop) begin
      r_a  <= w_rdData[2*WIDTH-1:WIDTH];
      r_b  <= w_rdData[WIDTH-1:0];
      r_en <= 1'b1;
    end else begin
      r_en <= 1'b0;
    end
  end

  assign bus.A  = r_a;
  assign bus.B  = r_b;
  assign bus.en = r_en;
  assign count  = r_count;

endmodule

// File: tb/tb_add_operand_fifo.sv
// -----------------------------------------------------------------------------
// tb_add_operand_fifo
// Drives add_operand_fifo through directed and randomized sequences and checks
// every cycle against a queue-based model of the feeder.
// -----------------------------------------------------------------------------
module tb_add_operand_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          hold  = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] count;

  add_operand_if #(.WIDTH(WIDTH)) bus ();

  add_operand_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .hold  (hold),
    .flush (flush),
    .count (count)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: queue of buffered {a, b} pairs plus expected issue outputs.
  logic [2*WIDTH-1:0] refQ [$];
  logic [WIDTH-1:0]   expA  = '0;
  logic [WIDTH-1:0]   expB  = '0;
  logic               expEn = 1'b0;
  logic               lastAccepted = 1'b1;

  // One comparison with failure accounting.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all visible outputs against the model.
  task automatic checkOutput(input string tag);
    checkVal({tag, ".en"},       32'(bus.en),       32'(expEn));
    checkVal({tag, ".A"},        32'(bus.A),        32'(expA));
    checkVal({tag, ".B"},        32'(bus.B),        32'(expB));
    checkVal({tag, ".count"},    32'(count),        32'(refQ.size()));
    checkVal({tag, ".in_ready"}, 32'(bus.in_ready), 32'(refQ.size() != DEPTH));
  endtask

  // Behaviour of one clock edge in terms of the queue.
  task automatic modelEdge(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic h, input logic f);
    logic               pushOk;
    logic               popOk;
    logic [2*WIDTH-1:0] head;
    pushOk = v && (refQ.size() != DEPTH) && !f;
    popOk  = (refQ.size() != 0) && !h && !f;
    lastAccepted = pushOk;
    if (f) begin
      refQ.delete();
      expEn = 1'b0;
    end else begin
      if (popOk) begin
        head  = refQ.pop_front();
        expA  = head[2*WIDTH-1:WIDTH];
        expB  = head[WIDTH-1:0];
        expEn = 1'b1;
      end else begin
        expEn = 1'b0;
      end
      if (pushOk) refQ.push_back({a, b});
    end
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, check.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic h, input logic f, input string tag);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    hold         = h;
    flush        = f;
    @(posedge clk);
    modelEdge(v, a, b, h, f);
    #1;
    checkOutput(tag);
  endtask

  task automatic modelReset();
    refQ.delete();
    expA  = '0;
    expB  = '0;
    expEn = 1'b0;
  endtask

  initial begin
    logic             pv;
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
    logic             ph;

    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;

    // Reset: takes effect without waiting for a clock edge.
    #2 rst_n = 1'b0;
    #1 checkOutput("resetAsync");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 checkOutput("resetRelease");

    // Single pair: issue one edge after the push, then en drops and A/B hold.
    applyStimulus(1'b1, 4'h3, 4'h5, 1'b0, 1'b0, "singlePush");
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "singleIssue");
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "singleIdle");

    // Back-to-back burst of six pairs at full throughput.
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 4'(i), 4'(i), 1'b0, 1'b0, "burst");
    end
    repeat (2) applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "burstDrain");

    // Stall with hold: fill to DEPTH, fifth pair waits for ready.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 4'(i + 8), 4'(i), 1'b1, 1'b0, "holdFill");
    end
    repeat (2) applyStimulus(1'b1, 4'hD, 4'h2, 1'b1, 1'b0, "holdFull");
    applyStimulus(1'b1, 4'hD, 4'h2, 1'b0, 1'b0, "holdReleaseFull");
    applyStimulus(1'b1, 4'hD, 4'h2, 1'b0, 1'b0, "holdFifthAccept");
    repeat (5) applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "holdDrain");

    // Wrap traffic including an operand pair whose sum overflows.
    applyStimulus(1'b1, 4'hF, 4'h1, 1'b1, 1'b0, "wrapPrime");
    applyStimulus(1'b1, 4'h8, 4'h8, 1'b1, 1'b0, "wrapPrime");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 4'(15 - i), 4'(i), (i % 4) == 3, 1'b0, "wrapSteady");
    end
    repeat (4) applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "wrapDrain");

    // Randomized traffic; a refused pair is held stable until accepted.
    pv = 1'b0;
    pa = '0;
    pb = '0;
    lastAccepted = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (!(pv && !lastAccepted)) begin
        pv = ($urandom_range(0, 3) != 0);
        pa = 4'($urandom);
        pb = 4'($urandom);
      end
      ph = ($urandom_range(0, 4) == 0);
      applyStimulus(pv, pa, pb, ph, 1'b0, "rand");
    end
    repeat (5) applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "randDrain");

    // Flush with three buffered pairs and a pair presented in the same cycle.
    applyStimulus(1'b1, 4'h7, 4'h1, 1'b1, 1'b0, "flushFill");
    applyStimulus(1'b1, 4'h2, 4'h9, 1'b1, 1'b0, "flushFill");
    applyStimulus(1'b1, 4'h4, 4'h4, 1'b1, 1'b0, "flushFill");
    applyStimulus(1'b1, 4'hE, 4'hE, 1'b0, 1'b1, "flush");
    repeat (3) applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "postFlush");

    // Asynchronous reset in the middle of a burst (count 2, en high).
    applyStimulus(1'b1, 4'h6, 4'h3, 1'b1, 1'b0, "midFill");
    applyStimulus(1'b1, 4'hA, 4'h5, 1'b1, 1'b0, "midFill");
    applyStimulus(1'b1, 4'hC, 4'h1, 1'b1, 1'b0, "midFill");
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "midIssue");
    #2 rst_n = 1'b0;
    modelReset();
    #1 checkOutput("midReset");
    #2 rst_n = 1'b1;
    applyStimulus(1'b1, 4'h3, 4'h5, 1'b0, 1'b0, "afterResetPush");
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "afterResetIssue");
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "afterResetIdle");

    $display("[TB] stimulus complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_operand_fifo.md
Name: add_operand_fifo

Overview:
- Upstream feeder for the 4-bit registered adder stage.
- Accepts operand pairs (a, b) from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Issues one pair per cycle to the adder as registered A, B plus a one-cycle en strobe, so the adder captures exactly one sum per accepted pair.
- Supports a downstream stall (hold) and a synchronous flush.

Parameters:
- WIDTH, 4, operand width in bits; matches the adder A/B width.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- CW, $clog2(DEPTH)+1, width of the occupancy count; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer presents a pair this cycle.
- in_ready  output  1  FIFO can accept a pair; equals (count != DEPTH).
- in_a  input  WIDTH  operand A from producer.
- in_b  input  WIDTH  operand B from producer.
- hold  input  1  downstream stall; no issue while high.
- flush  input  1  synchronous clear of all buffered pairs.
- A  output  WIDTH  registered operand A to adder.
- B  output  WIDTH  registered operand B to adder.
- en  output  1  registered one-cycle issue strobe to adder.
- count  output  CW  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr, rd_ptr and count go to 0; A and B go to 0; en goes to 0; in_ready is 1. FIFO storage is not reset.
- Push: occurs at a clock edge when in_valid && in_ready && !flush; writes {in_a, in_b} at wr_ptr, then wr_ptr increments, wrapping modulo DEPTH.
- Pop/issue: occurs at a clock edge when count != 0 && !hold && !flush.
  - A <= head a, B <= head b, en <= 1.
  - rd_ptr increments, wrapping modulo DEPTH.
- Otherwise en <= 0 and A, B hold their previous values.
- en is never high for two cycles unless consecutive pops occur. Each pop produces exactly one en cycle.
- No fall-through:
  - A pair pushed at edge k into an empty FIFO is popped at edge k+1, so en is high during cycle k+1..k+2.
  - The adder captures its sum at edge k+2.
  - Push-to-issue latency is 1 cycle; push-to-sum latency is 2 cycles.
- Throughput: one pair per cycle sustained when in_valid is continuous and hold is low. count stays constant on simultaneous push and pop.
- Full:
  - in_ready is computed from registered count, so it is 0 whenever count == DEPTH, even if a pop happens in the same cycle.
  - A pair presented while full is not accepted; the producer must keep it stable until in_ready.
- Empty: no pop and en <= 0, regardless of hold.
- hold high: no pop; en <= 0 on the next edge; A and B keep their last issued values. Pushes continue until full.
- flush high (synchronous, has priority over push and pop):
  - Next edge sets count <= 0, wr_ptr <= rd_ptr <= 0, and en <= 0.
  - A and B are unchanged.
  - in_valid in that cycle is ignored.
- count update: count + push - pop, where push and pop are the qualified events above. count never exceeds DEPTH and never goes below 0.
- Ordering: pairs are issued strictly in acceptance order. Pointers wrap seamlessly across the DEPTH boundary.
- Reset mid-stream: all buffered pairs are discarded immediately. en drops asynchronously with rst_n.

Decomposition:
- No shared package types are needed; WIDTH and DEPTH are passed down from the adder top level.
- One natural sub-module: add_operand_mem, a DEPTH x 2*WIDTH register array with a write port and a combinational read port. Pointer, count, handshake and issue logic stay in add_operand_fifo.

Test Plan:
- Reset then single push of a=4'h3, b=4'h5 at edge 1 -> en=1 in cycle after edge 2 with A=3, B=5; adder S=4'h8 after edge 3; count returns to 0.
- Burst of 6 back-to-back pairs (1,1),(2,2),...,(6,6) with hold=0 -> in_ready stays 1; en high 6 consecutive cycles; A/B follow input order; S sequence is 2,4,6,8,A,C.
- hold=1 while pushing 5 pairs (DEPTH=4) -> count saturates at 4; in_ready=0; 5th pair stalls. Release hold -> 5 issues in order; 5th pair accepted once in_ready rises.
- Wrap check: push/pop 10 pairs through a FIFO kept at 2–3 entries -> no loss or duplication; values such as (F,1) issue with sum wrap S=4'h0.
- flush with count=3 and in_valid=1 -> next cycle count=0, en=0, in_ready=1, the flushed pairs never issue, and A/B retain their old values.
- Async reset asserted mid-burst (count=2, en=1) -> en, A, B and count go to 0 immediately without a clock; after release, the first push issues normally.
